// File: rtl/duck_sprite_ctrl.sv
// Duck sprite sequencer: on-screen position, per-frame FLY/HIT/FALL/GONE stepping and ROM address lookahead.
// Optional colour-key transparency is enabled by defining DUCK_TRANSPARENT_EN.
module duck_sprite_ctrl #(
  parameter int unsigned SPR_W          = 124,
  parameter int unsigned SPR_H          = 162,
  parameter int unsigned H_VIS          = 640,
  parameter int unsigned H_TOT          = 800,
  parameter int unsigned V_VIS          = 480,
  parameter int unsigned X0             = 0,
  parameter int unsigned Y0             = 0,
  parameter int unsigned STEP           = 2,
  parameter int unsigned FALL_STEP      = 4,
  parameter int unsigned HIT_FRAMES     = 30,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        hit,
  output logic [14:0] rom_addr,
  input  logic [5:0]  rom_data,
  output logic [5:0]  pix_out,
  output logic        pix_valid,
  output logic [1:0]  duck_state,
  output logic        frame_tick
);

  // state   | meaning
  // ST_FLY  | bouncing inside the visible area, hit-able
  // ST_HIT  | frozen in place for HIT_FRAMES frames
  // ST_FALL | dropping FALL_STEP lines per frame
  // ST_GONE | hidden for RESPAWN_FRAMES frames, then respawn at X0/Y0
  typedef enum logic [1:0] {
    ST_FLY  = 2'd0,
    ST_HIT  = 2'd1,
    ST_FALL = 2'd2,
    ST_GONE = 2'd3
  } state_t;

  localparam logic [10:0] X_MAX = 11'(H_VIS - SPR_W);
  localparam logic [10:0] Y_MAX = 11'(V_VIS - SPR_H);

  state_t      state_q;
  logic [9:0]  x_q, y_q;
  logic        dir_x_q, dir_y_q;
  logic [7:0]  hold_q;
  logic [14:0] line_base_q;
  logic [14:0] rom_addr_q;
  logic        in_box_d_q;
  logic [5:0]  pix_out_q;
  logic        pix_valid_q;
  logic        frame_tick_q;

  logic [9:0]  x_d, y_d;
  logic        dir_x_d, dir_y_d;

  logic [10:0] col;
  logic [10:0] x_end, y_end;
  logic        in_box, last_col, tick_now, pix_ok;
  logic [14:0] addr_now;

  // Lookahead column is two pixels ahead; no wrap into the next line.
  assign col      = {1'b0, hcount} + 11'd2;
  assign x_end    = {1'b0, x_q} + 11'(SPR_W);
  assign y_end    = {1'b0, y_q} + 11'(SPR_H);
  assign tick_now = (hcount == 10'd0) && (vcount == 10'(V_VIS));

  assign in_box = (state_q != ST_GONE) && (col < 11'(H_TOT)) &&
                  (col >= {1'b0, x_q}) && (col < x_end) &&
                  (vcount >= y_q) && ({1'b0, vcount} < y_end);
  assign last_col = in_box && (col == x_end - 11'd1);
  assign addr_now = line_base_q + 15'(col - {1'b0, x_q});

`ifdef DUCK_TRANSPARENT_EN
  assign pix_ok = (rom_data != 6'd0);
`else
  assign pix_ok = 1'b1;
`endif

  // Bounce: clamp to the edge and reverse when a step would overshoot.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (dir_x_q) begin
      if ({1'b0, x_q} + 11'(STEP) > X_MAX) begin
        x_d     = X_MAX[9:0];
        dir_x_d = 1'b0;
      end else begin
        x_d = x_q + 10'(STEP);
      end
    end else begin
      if (x_q < 10'(STEP)) begin
        x_d     = 10'd0;
        dir_x_d = 1'b1;
      end else begin
        x_d = x_q - 10'(STEP);
      end
    end
    if (dir_y_q) begin
      if ({1'b0, y_q} + 11'(STEP) > Y_MAX) begin
        y_d     = Y_MAX[9:0];
        dir_y_d = 1'b0;
      end else begin
        y_d = y_q + 10'(STEP);
      end
    end else begin
      if (y_q < 10'(STEP)) begin
        y_d     = 10'd0;
        dir_y_d = 1'b1;
      end else begin
        y_d = y_q - 10'(STEP);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q      <= ST_FLY;
      x_q          <= 10'(X0);
      y_q          <= 10'(Y0);
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      hold_q       <= 8'd0;
      line_base_q  <= 15'd0;
      rom_addr_q   <= 15'd0;
      in_box_d_q   <= 1'b0;
      pix_out_q    <= 6'd0;
      pix_valid_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= tick_now;
      in_box_d_q   <= in_box;
      pix_out_q    <= rom_data;
      pix_valid_q  <= in_box_d_q && pix_ok;
      // Address is held outside the box so the ROM does not toggle.
      if (in_box) begin
        rom_addr_q <= addr_now;
      end
      if (tick_now) begin
        line_base_q <= 15'd0;
      end else if (last_col) begin
        line_base_q <= line_base_q + 15'(SPR_W);
      end

      case (state_q)
        ST_FLY: begin
          if (hit) begin
            state_q <= ST_HIT;
            hold_q  <= 8'(HIT_FRAMES - 1);
          end else if (tick_now) begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
          end
        end
        ST_HIT: begin
          if (tick_now) begin
            if (hold_q == 8'd0) begin
              state_q <= ST_FALL;
            end else begin
              hold_q <= hold_q - 8'd1;
            end
          end
        end
        ST_FALL: begin
          if (tick_now) begin
            if ({1'b0, y_q} + 11'(FALL_STEP) >= 11'(V_VIS)) begin
              state_q <= ST_GONE;
              hold_q  <= 8'(RESPAWN_FRAMES - 1);
            end else begin
              y_q <= y_q + 10'(FALL_STEP);
            end
          end
        end
        ST_GONE: begin
          if (tick_now) begin
            if (hold_q == 8'd0) begin
              state_q <= ST_FLY;
              x_q     <= 10'(X0);
              y_q     <= 10'(Y0);
              dir_x_q <= 1'b1;
              dir_y_q <= 1'b1;
            end else begin
              hold_q <= hold_q - 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign duck_state = state_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_duck_sprite_ctrl.sv
// Directed bench for duck_sprite_ctrl: table-driven scan of the sprite box plus hand-written frame sequences.
module tb_duck_sprite_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic        hit;
  logic [14:0] rom_addr;
  logic [5:0]  rom_data;
  logic [5:0]  pix_out;
  logic        pix_valid;
  logic [1:0]  duck_state;
  logic        frame_tick;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef DUCK_TRANSPARENT_EN
  localparam int KEY_VALID = 0;
`else
  localparam int KEY_VALID = 1;
`endif

  duck_sprite_ctrl dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .hit        (hit),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .duck_state (duck_state),
    .frame_tick (frame_tick)
  );

  // ROM contents: low six address bits, so address 64*k reads as the colour key.
  assign rom_data = rom_addr[5:0];

  always #20 vga_clk = ~vga_clk;

  typedef struct {
    int v;
    int h;
    int valid;
    int addr;
    int pix;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Present one pixel position; outputs afterwards reflect the edge that sampled it.
  task automatic cyc(input int h, input int v, input logic ht);
    hcount = 10'(h);
    vcount = 10'(v);
    hit    = ht;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 480, 1'b0);
      chk("frame_tick_hi", int'(frame_tick), 1);
      cyc(1, 480, 1'b0);
      chk("frame_tick_lo", int'(frame_tick), 0);
    end
  endtask

  // Locate the sprite via rom_addr on its first row (line_base is 0 right after a frame tick).
  task automatic probe(input string nm, input int xe, input int ye);
    cyc(xe + 3, ye, 1'b0);
    chk({nm, "_off5"}, int'(rom_addr), 5);
    if (ye > 0) begin
      cyc(xe + 5, ye - 1, 1'b0);
      chk({nm, "_row_above"}, int'(rom_addr), 5);
    end
    if (xe >= 3) begin
      cyc(xe - 3, ye, 1'b0);
      chk({nm, "_col_left"}, int'(rom_addr), 5);
    end
    cyc(xe + 122, ye, 1'b0);
    chk({nm, "_col_right"}, int'(rom_addr), 5);
    if (xe >= 2) begin
      cyc(xe - 2, ye, 1'b0);
      chk({nm, "_col0"}, int'(rom_addr), 0);
    end
  endtask

  initial begin
    // Values seen while hcount==h on line v (pipeline primed by the preceding pixel).
    tbl[0]  = '{v:0,   h:0,   valid:0,         addr:0,     pix:0};
    tbl[1]  = '{v:0,   h:1,   valid:0,         addr:2,     pix:0};
    tbl[2]  = '{v:0,   h:2,   valid:1,         addr:3,     pix:2};
    tbl[3]  = '{v:0,   h:63,  valid:1,         addr:64,    pix:63};
    tbl[4]  = '{v:0,   h:64,  valid:KEY_VALID, addr:65,    pix:0};
    tbl[5]  = '{v:0,   h:123, valid:1,         addr:123,   pix:59};
    tbl[6]  = '{v:0,   h:124, valid:0,         addr:123,   pix:59};
    tbl[7]  = '{v:1,   h:1,   valid:0,         addr:126,   pix:59};
    tbl[8]  = '{v:1,   h:2,   valid:1,         addr:127,   pix:62};
    tbl[9]  = '{v:161, h:123, valid:1,         addr:20087, pix:55};
    tbl[10] = '{v:161, h:124, valid:0,         addr:20087, pix:55};
    tbl[11] = '{v:162, h:2,   valid:0,         addr:20087, pix:55};

    reset = 1'b1;
    cyc(0, 0, 1'b0);
    cyc(0, 0, 1'b0);
    reset = 1'b0;
    chk("reset_state", int'(duck_state), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);
    chk("reset_pix_valid", int'(pix_valid), 0);

    for (int v = 0; v <= 162; v++) begin
      for (int h = 0; h < 128; h++) begin
        for (int k = 0; k < 12; k++) begin
          if (tbl[k].v == v && tbl[k].h == h) begin
            chk($sformatf("scan_v%0d_h%0d_valid", v, h), int'(pix_valid), tbl[k].valid);
            chk($sformatf("scan_v%0d_h%0d_addr", v, h), int'(rom_addr), tbl[k].addr);
            chk($sformatf("scan_v%0d_h%0d_pix", v, h), int'(pix_out), tbl[k].pix);
          end
        end
        cyc(h, v, 1'b0);
      end
    end

    // Flight and bounce at the right/bottom limits.
    frames(1);
    probe("fly1", 2, 2);
    frames(256);
    probe("fly257", 514, 124);
    frames(1);
    probe("fly258", 516, 122);
    frames(1);
    probe("fly259_clamp", 516, 120);
    frames(1);
    probe("fly260_back", 514, 118);

    // Hit, freeze, fall, vanish, respawn.
    cyc(5, 10, 1'b1);
    chk("hit_to_HIT", int'(duck_state), 1);
    cyc(5, 10, 1'b1);
    chk("hit_in_HIT", int'(duck_state), 1);
    frames(29);
    chk("hit_29_frames", int'(duck_state), 1);
    probe("hit_frozen", 514, 118);
    frames(1);
    chk("hit_30_frames", int'(duck_state), 2);
    frames(1);
    probe("fall1", 514, 122);
    cyc(5, 10, 1'b1);
    chk("hit_in_FALL", int'(duck_state), 2);
    cyc(5, 10, 1'b0);
    frames(88);
    probe("fall89", 514, 474);
    frames(1);
    chk("fall90_state", int'(duck_state), 2);
    probe("fall90", 514, 478);
    frames(1);
    chk("fall_to_GONE", int'(duck_state), 3);
    cyc(514, 478, 1'b0);
    cyc(515, 478, 1'b0);
    cyc(516, 478, 1'b0);
    chk("gone_pix_valid", int'(pix_valid), 0);
    chk("gone_addr_held", int'(rom_addr), 0);
    frames(59);
    chk("gone_59_frames", int'(duck_state), 3);
    frames(1);
    chk("respawn_state", int'(duck_state), 0);
    probe("respawn", 0, 0);

    // Hit coincident with frame tick: hit wins, no move.
    frames(3);
    probe("fly3", 6, 6);
    cyc(0, 480, 1'b1);
    chk("hit_tick_state", int'(duck_state), 1);
    chk("hit_tick_frame_tick", int'(frame_tick), 1);
    cyc(1, 480, 1'b0);
    probe("hit_tick_pos", 6, 6);
    frames(30);
    chk("hit2_to_FALL", int'(duck_state), 2);
    frames(2);
    probe("fall2", 6, 14);

    // Reset mid-fall, on a tick position.
    reset = 1'b1;
    cyc(0, 480, 1'b0);
    reset = 1'b0;
    chk("rst2_state", int'(duck_state), 0);
    chk("rst2_frame_tick", int'(frame_tick), 0);
    chk("rst2_addr", int'(rom_addr), 0);
    chk("rst2_pix_out", int'(pix_out), 0);
    chk("rst2_pix_valid", int'(pix_valid), 0);
    probe("rst2_pos", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
